// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex-to-segment table for the four-digit scan controller.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] DIG_OFF   = 4'hF;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_e;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] hex;
  } digit_t;

  localparam digit_t ENTRY_BLANK = '{blank: 1'b1, dp: 1'b0, hex: 4'h0};

  // Active-low {dp,g,f,e,d,c,b,a} with the decimal point off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
    logic [7:0] s;
    case (hex)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational decode of one digit entry into the active-low segment byte.
module seg7_hex_decode (
  input  seg7_pkg::digit_t entry_i,
  output logic [7:0]       seg_o
);
  import seg7_pkg::*;

  always_comb begin
    seg_o = entry_i.blank ? SEG_BLANK : hex_to_seg(entry_i.hex);
    if (entry_i.dp) seg_o[7] = 1'b0;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode scan controller with frame-synchronous shadow commit and per-slot blanking.
// Optional brightness dimming is enabled by defining SEG7_DIM_EN (adds the bright input).
module seg7_scan_ctrl #(
  parameter int SCAN_DIV  = 6250,
  parameter int BLANK_CYC = 64
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef SEG7_DIM_EN
  input  logic [1:0] bright,
`endif
  input  logic       wr_en,
  input  logic [1:0] wr_idx,
  input  logic       wr_blank,
  input  logic [3:0] wr_hex,
  input  logic       wr_dp,
  output logic       wr_ready,
  output logic [7:0] seg,
  output logic [3:0] dig,
  output logic       frame_tick
);
  import seg7_pkg::*;

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       slot_q;
  state_e           state_q;
  digit_t           shadow_q [4];
  digit_t           active_q [4];
  logic             dirty_q;
  logic [7:0]       seg_q;
  logic [3:0]       dig_q;
  logic             frame_tick_q;

  logic             commit;
  logic             wr_accept;
  logic             lit;
  logic [7:0]       dec_seg;
  digit_t           cur_entry;
  digit_t           wr_entry;

  assign commit    = (cnt_q == CNT_LAST) && (slot_q == 2'd3);
  assign wr_ready  = ~commit;
  assign wr_accept = wr_en & wr_ready;
  assign wr_entry  = '{blank: wr_blank, dp: wr_dp, hex: wr_hex};
  assign cur_entry = active_q[slot_q];

  seg7_hex_decode u_decode (
    .entry_i (cur_entry),
    .seg_o   (dec_seg)
  );

`ifdef SEG7_DIM_EN
  logic [1:0]  bright_q;
  logic [31:0] show_off;
  logic [31:0] lit_lim;

  // Offset into the SHOW window; only meaningful while state_q is ST_SHOW.
  assign show_off = 32'(cnt_q) - 32'(BLANK_CYC);
  assign lit_lim  = (32'(SCAN_DIV - BLANK_CYC) * (32'(bright_q) + 32'd1)) >> 2;
  assign lit      = show_off < lit_lim;

  always_ff @(posedge clk) begin
    if (!rst_n)              bright_q <= 2'd3;
    else if (cnt_q == '0)    bright_q <= bright;
  end
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      slot_q       <= 2'd0;
      state_q      <= ST_BLANK;
      dirty_q      <= 1'b0;
      seg_q        <= SEG_BLANK;
      dig_q        <= DIG_OFF;
      frame_tick_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= ENTRY_BLANK;
        active_q[i] <= ENTRY_BLANK;
      end
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_q  <= '0;
        slot_q <= slot_q + 2'd1;
      end else begin
        cnt_q  <= cnt_q + CNT_W'(1);
      end

      case (state_q)
        ST_BLANK: begin
          seg_q <= SEG_BLANK;
          dig_q <= DIG_OFF;
          if (cnt_q == BLANK_LAST) state_q <= ST_SHOW;
        end
        ST_SHOW: begin
          if (lit) begin
            seg_q <= dec_seg;
            dig_q <= ~(4'b0001 << slot_q);
          end else begin
            seg_q <= SEG_BLANK;
            dig_q <= DIG_OFF;
          end
          if (cnt_q == CNT_LAST) state_q <= ST_BLANK;
        end
      endcase

      frame_tick_q <= commit;

      // Writes are refused during the commit cycle, so the two never collide.
      if (commit) begin
        if (dirty_q) begin
          active_q <= shadow_q;
          dirty_q  <= 1'b0;
        end
      end else if (wr_accept) begin
        shadow_q[wr_idx] <= wr_entry;
        dirty_q          <= 1'b1;
      end
    end
  end

  assign seg        = seg_q;
  assign dig        = dig_q;
  assign frame_tick = frame_tick_q;

endmodule
